// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg
//   Shared definitions for the ALU operation sequencer:
//   - 3-bit opcode constants (same encoding on req_op, alu_sel and rsp_op)
//   - sequencer state encoding
//   - is_arith(): true for opcodes whose carry/overflow flags are meaningful
package alu_op_sequencer_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_OR   = 3'b111;

  localparam int SETTLE_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  // ADD, SUB and SLT occupy the low end of the opcode space; everything
  // above is a bitwise op whose carry/overflow outputs are meaningless.
  function automatic logic is_arith(input logic [2:0] op);
    return (op <= OP_SLT);
  endfunction

endpackage

// File: rtl/alu_settle_counter.sv
// alu_settle_counter
//   Loadable 4-bit down-counter used to time the ALU settle window.
//   Ports:
//     clk, reset_n   clock and asynchronous active-low reset
//     load           load count_reg with load_val (has priority over dec)
//     load_val       value to load
//     dec            decrement request; the counter saturates at zero
//     zero           count_reg == 0
module alu_settle_counter
  import alu_op_sequencer_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [SETTLE_CNT_W-1:0] load_val,
  input  logic                    dec,
  output logic                    zero
);

  logic [SETTLE_CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Issues one operation at a time to a combinational 32-bit ALU and collects
//   its result after a fixed settle window.
//   Ports:
//     clk, reset_n                 clock, asynchronous active-low reset
//     req_valid/req_ready          request handshake (req_op, req_a, req_b)
//     alu_sel/alu_a/alu_b          registered ALU drive, changes only on accept
//     alu_result/alu_carryout/
//     alu_overflow/alu_zero        ALU outputs, sampled at end of settle window
//     rsp_valid/rsp_ready          response handshake (rsp_op, rsp_result,
//                                  rsp_carryout, rsp_overflow, rsp_zero)
//     op_count                     completed responses, wraps modulo 2^CNT_W
//   Accept at edge N captures the ALU outputs at edge N+SETTLE_CYCLES.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,   // legal range 1..15
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic [2:0]       alu_sel,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_result,
  input  logic             alu_carryout,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2:0]       rsp_op,
  output logic [31:0]      rsp_result,
  output logic             rsp_carryout,
  output logic             rsp_overflow,
  output logic             rsp_zero,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  state_t state_reg, state_next;

  logic accept, capture, complete, cnt_dec, cnt_zero;

  logic [2:0]       alu_sel_reg;
  logic [31:0]      alu_a_reg, alu_b_reg;
  logic [2:0]       rsp_op_reg;
  logic [31:0]      rsp_result_reg;
  logic             rsp_carryout_reg, rsp_overflow_reg, rsp_zero_reg;
  logic [CNT_W-1:0] op_count_reg;

  alu_settle_counter u_settle_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (accept),
    .load_val (SETTLE_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = SETTLE;
      SETTLE:  if (cnt_zero)  state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / strobe logic
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    complete  = 1'b0;
    cnt_dec   = 1'b0;
    case (state_reg)
      IDLE: begin
        // Ready is withheld while reset is asserted so nothing is offered
        // as accepted during reset; it rises as soon as reset releases.
        req_ready = reset_n;
        accept    = req_valid;
      end
      SETTLE: begin
        capture = cnt_zero;
        cnt_dec = !cnt_zero;
      end
      RESP: begin
        rsp_valid = 1'b1;
        complete  = rsp_ready;
      end
      default: ;
    endcase
  end

  // ALU drive, response capture and completion counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_sel_reg      <= '0;
      alu_a_reg        <= '0;
      alu_b_reg        <= '0;
      rsp_op_reg       <= '0;
      rsp_result_reg   <= '0;
      rsp_carryout_reg <= 1'b0;
      rsp_overflow_reg <= 1'b0;
      rsp_zero_reg     <= 1'b0;
      op_count_reg     <= '0;
    end else begin
      if (accept) begin
        alu_sel_reg <= req_op;
        alu_a_reg   <= req_a;
        alu_b_reg   <= req_b;
      end
      if (capture) begin
        // alu_sel still holds the accepted opcode, so it doubles as the
        // latched opcode for the response.
        rsp_op_reg       <= alu_sel_reg;
        rsp_result_reg   <= alu_result;
        rsp_zero_reg     <= alu_zero;
        rsp_carryout_reg <= is_arith(alu_sel_reg) & alu_carryout;
        rsp_overflow_reg <= is_arith(alu_sel_reg) & alu_overflow;
      end
      if (complete) begin
        op_count_reg <= op_count_reg + CNT_W'(1);
      end
    end
  end

  assign alu_sel      = alu_sel_reg;
  assign alu_a        = alu_a_reg;
  assign alu_b        = alu_b_reg;
  assign rsp_op       = rsp_op_reg;
  assign rsp_result   = rsp_result_reg;
  assign rsp_carryout = rsp_carryout_reg;
  assign rsp_overflow = rsp_overflow_reg;
  assign rsp_zero     = rsp_zero_reg;
  assign op_count     = op_count_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
//   Directed bench: a table of ALU operations with hand-computed responses on
//   a SETTLE_CYCLES=4 / CNT_W=16 instance, hand-written backpressure and
//   mid-operation reset sequences, and a SETTLE_CYCLES=1 / CNT_W=2 instance
//   for counter wrap and back-to-back throughput.
//   Latency is counted in clock edges from the accept edge to the capture
//   edge (expected SETTLE_CYCLES).
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  localparam int SC  = 4;
  localparam int SC2 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // Instance 1 (SETTLE_CYCLES=4, CNT_W=16)
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2:0]  req_op, alu_sel, rsp_op;
  logic [31:0] req_a, req_b, alu_a, alu_b, alu_result, rsp_result;
  logic        alu_carryout, alu_overflow, alu_zero;
  logic        rsp_carryout, rsp_overflow, rsp_zero;
  logic [15:0] op_count;
  logic        force_c, force_v;

  // Instance 2 (SETTLE_CYCLES=1, CNT_W=2)
  logic        req_valid2, req_ready2, rsp_valid2, rsp_ready2;
  logic [2:0]  req_op2, alu_sel2, rsp_op2;
  logic [31:0] req_a2, req_b2, alu_a2, alu_b2, alu_result2, rsp_result2;
  logic        alu_carryout2, alu_overflow2, alu_zero2;
  logic        rsp_carryout2, rsp_overflow2, rsp_zero2;
  logic [1:0]  op_count2;

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        v;
    logic        z;
  } alu_out_t;

  // Behavioural ALU: arithmetic flags from the adder, SLT rewritten to 0/1,
  // logic-op carry/overflow driven by force flags to emulate garbage.
  function automatic alu_out_t alu_model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic fc, input logic fv);
    alu_out_t    o;
    logic [32:0] s;
    o = '0;
    s = '0;
    case (op)
      OP_ADD: begin
        s   = {1'b0, a} + {1'b0, b};
        o.r = s[31:0];
        o.c = s[32];
        o.v = (a[31] == b[31]) && (s[31] != a[31]);
      end
      OP_SUB, OP_SLT: begin
        s   = {1'b0, a} + {1'b0, ~b} + 33'd1;
        o.c = s[32];
        o.v = (a[31] != b[31]) && (s[31] != a[31]);
        o.r = (op == OP_SUB) ? s[31:0] : {31'd0, s[31] ^ o.v};
      end
      OP_XOR:  begin o.r = a ^ b;    o.c = fc; o.v = fv; end
      OP_AND:  begin o.r = a & b;    o.c = fc; o.v = fv; end
      OP_NAND: begin o.r = ~(a & b); o.c = fc; o.v = fv; end
      OP_NOR:  begin o.r = ~(a | b); o.c = fc; o.v = fv; end
      default: begin o.r = a | b;    o.c = fc; o.v = fv; end
    endcase
    o.z = (o.r == 32'd0);
    return o;
  endfunction

  alu_out_t m1, m2;
  always_comb m1 = alu_model(alu_sel, alu_a, alu_b, force_c, force_v);
  always_comb m2 = alu_model(alu_sel2, alu_a2, alu_b2, 1'b0, 1'b0);
  assign alu_result    = m1.r;
  assign alu_carryout  = m1.c;
  assign alu_overflow  = m1.v;
  assign alu_zero      = m1.z;
  assign alu_result2   = m2.r;
  assign alu_carryout2 = m2.c;
  assign alu_overflow2 = m2.v;
  assign alu_zero2     = m2.z;

  alu_op_sequencer #(.SETTLE_CYCLES(SC), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_carryout(alu_carryout), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_result(rsp_result),
    .rsp_carryout(rsp_carryout), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
    .op_count(op_count)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(SC2), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_op(req_op2), .req_a(req_a2), .req_b(req_b2),
    .alu_sel(alu_sel2), .alu_a(alu_a2), .alu_b(alu_b2),
    .alu_result(alu_result2), .alu_carryout(alu_carryout2), .alu_overflow(alu_overflow2),
    .alu_zero(alu_zero2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_op(rsp_op2), .rsp_result(rsp_result2),
    .rsp_carryout(rsp_carryout2), .rsp_overflow(rsp_overflow2), .rsp_zero(rsp_zero2),
    .op_count(op_count2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present a request and wait for it to be accepted; returns edges waited.
  task automatic accept_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int edges);
    logic rdy;
    rdy   = 1'b0;
    edges = 0;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    while (!rdy && edges < 40) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk); #1;
      edges++;
    end
    req_valid = 1'b0;
    if (!rdy) check("accept_timeout", 32'(rdy), 32'd1);
  endtask

  // Wait for rsp_valid (returns at that negedge); checks ALU drive stays put.
  task automatic wait_rsp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
    logic seen, hold_ok;
    seen = 1'b0; hold_ok = 1'b1; lat = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
      else begin
        hold_ok = hold_ok && (alu_sel === op) && (alu_a === a) && (alu_b === b);
        @(posedge clk); #1;
        lat++;
      end
    end
    check("rsp_timeout", 32'(seen), 32'd1);
    check("alu_inputs_held", 32'(hold_ok), 32'd1);
  endtask

  // Handshake edge with rsp_ready=1, then check the counter and return to IDLE.
  task automatic finish_rsp();
    @(posedge clk); #1;
    exp_count++;
    check("op_count", 32'(op_count), exp_count);
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        fc, fv;
    logic [31:0] r;
    logic        c, v, z;
  } vec_t;

  vec_t vecs[12];
  int   exp_seq[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lat;

    vecs[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000001, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{OP_SLT,  32'h00000005, 32'h00000003, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{OP_XOR,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{OP_SUB,  32'h00000009, 32'h00000004, 1'b0, 1'b0, 32'h00000005, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{OP_SUB,  32'h00000004, 32'h00000009, 1'b0, 1'b0, 32'hFFFFFFFB, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 1'b0, 32'hF000F000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{OP_NAND, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{OP_NOR,  32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{OP_OR,   32'h12340000, 32'h00005678, 1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{OP_SUB,  32'h80000000, 32'h00000001, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    exp_seq = '{1, 2, 3, 0, 1};

    reset_n = 1'b0;
    req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    req_valid2 = 1'b0; req_op2 = '0; req_a2 = '0; req_b2 = '0; rsp_ready2 = 1'b1;
    force_c = 1'b0; force_v = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_sel", 32'(alu_sel), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_flags", 32'({rsp_op, rsp_carryout, rsp_overflow, rsp_zero}), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    check("idle_req_ready", 32'(req_ready), 32'd1);

    // Table-driven operations, rsp_ready held high
    for (int i = 0; i < 12; i++) begin
      force_c = vecs[i].fc;
      force_v = vecs[i].fv;
      accept_req(vecs[i].op, vecs[i].a, vecs[i].b, n);
      wait_rsp(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check("latency", 32'(lat), 32'(SC));
      check("rsp_result", rsp_result, vecs[i].r);
      check("rsp_carryout", 32'(rsp_carryout), 32'(vecs[i].c));
      check("rsp_overflow", 32'(rsp_overflow), 32'(vecs[i].v));
      check("rsp_zero", 32'(rsp_zero), 32'(vecs[i].z));
      check("rsp_op", 32'(rsp_op), 32'(vecs[i].op));
      $display("op %0d: sel=%0d a=%08h b=%08h -> result=%08h c=%0b v=%0b z=%0b lat=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, rsp_result, rsp_carryout, rsp_overflow,
               rsp_zero, lat);
      finish_rsp();
    end
    force_c = 1'b0;
    force_v = 1'b0;

    // Backpressure: response held 10 cycles while a second request waits
    rsp_ready = 1'b0;
    accept_req(OP_OR, 32'h0F0F0000, 32'h000000F0, n);
    wait_rsp(OP_OR, 32'h0F0F0000, 32'h000000F0, lat);
    check("bp_latency", 32'(lat), 32'(SC));
    req_op = OP_ADD; req_a = 32'd10; req_b = 32'd20; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_result", rsp_result, 32'h0F0F00F0);
      check("bp_rsp_op", 32'(rsp_op), 32'(OP_OR));
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    $display("backpressure: held result=%08h for 10 cycles", rsp_result);
    rsp_ready = 1'b1;
    finish_rsp();
    accept_req(OP_ADD, 32'd10, 32'd20, n);
    check("bp_accept_gap", 32'(n), 32'd1);
    wait_rsp(OP_ADD, 32'd10, 32'd20, lat);
    check("bp2_result", rsp_result, 32'd30);
    $display("backpressure: second op accepted %0d edge after release, result=%0d", n, rsp_result);
    finish_rsp();

    // Reset during SETTLE of SUB 9-4, with the next request pending across release
    accept_req(OP_SUB, 32'd9, 32'd4, n);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    exp_count = 0;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_alu_sel", 32'(alu_sel), 32'd0);
    check("mid_rst_alu_a", alu_a, 32'd0);
    check("mid_rst_alu_b", alu_b, 32'd0);
    check("mid_rst_rsp_result", rsp_result, 32'd0);
    check("mid_rst_op_count", 32'(op_count), 32'd0);
    req_op = OP_ADD; req_a = 32'd2; req_b = 32'd3; req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    accept_req(OP_ADD, 32'd2, 32'd3, n);
    check("post_rst_accept_edge", 32'(n), 32'd1);
    wait_rsp(OP_ADD, 32'd2, 32'd3, lat);
    check("post_rst_latency", 32'(lat), 32'(SC));
    check("post_rst_result", rsp_result, 32'd5);
    $display("reset: pending op accepted on edge %0d after release, result=%0d", n, rsp_result);
    finish_rsp();

    // Instance 2: CNT_W=2 wrap and back-to-back throughput, SETTLE_CYCLES=1
    req_valid2 = 1'b1;
    req_op2    = OP_ADD;
    req_b2     = 32'd1;
    for (int i = 0; i < 5; i++) begin
      logic rdy, seen;
      int   e, l;
      req_a2 = 32'(i);
      rdy = 1'b0; e = 0;
      while (!rdy && e < 20) begin
        @(negedge clk);
        rdy = req_ready2;
        @(posedge clk); #1;
        e++;
      end
      check("b2b_accept", 32'(rdy), 32'd1);
      if (i > 0) check("b2b_accept_gap", 32'(e), 32'd1);
      seen = 1'b0; l = 0;
      while (!seen && l < 20) begin
        @(negedge clk);
        if (rsp_valid2) seen = 1'b1;
        else begin
          @(posedge clk); #1;
          l++;
        end
      end
      check("b2b_rsp", 32'(seen), 32'd1);
      check("b2b_latency", 32'(l), 32'(SC2));
      check("b2b_result", rsp_result2, 32'(i + 1));
      @(posedge clk); #1;
      check("b2b_op_count", 32'(op_count2), 32'(exp_seq[i]));
      $display("b2b op %0d: result=%0d op_count=%0d lat=%0d", i, rsp_result2, op_count2, l);
    end
    req_valid2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
